// File: rtl/display_output_scheduler_pkg.sv
// Shared types and constants for the display output scheduler.
// The default pulse spacing is tied to one full scan of the 8-digit display.
package display_output_scheduler_pkg;

   localparam int DISP_DW  = 16;
   localparam int SCAN_LEN = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_HOLD  = 2'd2,
      ST_CLEAR = 2'd3
   } drain_state_e;

endpackage

// File: rtl/display_output_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched upward from the pointer,
// pointer moves past the winner, returns to 0 when the display is cleared.
module display_output_scheduler_rr_arbiter #(
   parameter int NREQ = 2
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [NREQ-1:0] req_i,
   input  logic            enable_i,
   input  logic            clear_i,
   output logic [NREQ-1:0] grant_o
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PW-1:0] ptr_q;
   logic [PW-1:0] ptr_d;
   logic [PW-1:0] idx;
   logic [PW:0]   sum;
   logic          found;

   // NOTE: every signal written here gets a default first, so no latch is inferred.
   always_comb begin
      grant_o = '0;
      ptr_d   = ptr_q;
      found   = 1'b0;
      sum     = '0;
      idx     = '0;
      for (int k = 0; k < NREQ; k++) begin
         sum = {1'b0, ptr_q} + (PW+1)'(k);
         if (sum >= (PW+1)'(NREQ)) begin
            sum = sum - (PW+1)'(NREQ);
         end
         idx = sum[PW-1:0];
         if (enable_i && !found && req_i[idx]) begin
            grant_o[idx] = 1'b1;
            found        = 1'b1;
            ptr_d        = (idx == PW'(NREQ-1)) ? '0 : idx + 1'b1;
         end
      end
      if (clear_i) begin
         ptr_d = '0;
      end
   end

   // NOTE: sequential state is updated with non-blocking assignments only.
   always_ff @(posedge clock) begin
      if (reset) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/display_output_scheduler.sv
// Collects requester writes into a small FIFO and replays them to the 7-segment
// history block as shift pulses spaced by at least one display scan; also sequences clears.
module display_output_scheduler
   import display_output_scheduler_pkg::*;
#(
   parameter int NREQ  = 2,
   parameter int DEPTH = 4,
   parameter int GAP   = SCAN_LEN,
   parameter int DW    = DISP_DW
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ*DW-1:0]       req_data,
   output logic [NREQ-1:0]          req_ack,
   input  logic                     clear_req,
   output logic                     disp_change,
   output logic                     disp_output,
   output logic [DW-1:0]            disp_data,
   output logic                     disp_clear,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int GW = $clog2(GAP + 1);

   drain_state_e  state_q;
   logic [GW-1:0] gap_q;
   logic          disp_change_q;
   logic          disp_output_q;
   logic          disp_clear_q;
   logic [DW-1:0] disp_data_q;

   logic [CW-1:0] count_q, count_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [DW-1:0] mem_q [DEPTH];

   logic            full;
   logic            in_clear;
   logic            pop;
   logic            push;
   logic            grant_en;
   logic [NREQ-1:0] grant;
   logic [DW-1:0]   push_data;

   // Fullness uses the registered count, so a full FIFO refuses even in its pop cycle.
   assign full     = (count_q == CW'(DEPTH));
   assign in_clear = (state_q == ST_CLEAR);
   assign pop      = (state_q == ST_ISSUE);
   assign grant_en = !reset && !full && !clear_req && !in_clear;
   assign push     = |grant;

   display_output_scheduler_rr_arbiter #(
      .NREQ(NREQ)
   ) u_arb (
      .clock    (clock),
      .reset    (reset),
      .req_i    (req_valid),
      .enable_i (grant_en),
      .clear_i  (in_clear),
      .grant_o  (grant)
   );

   always_comb begin
      push_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            push_data = req_data[i*DW +: DW];
         end
      end
   end

   always_comb begin
      count_d  = count_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (in_clear) begin
         count_d  = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // NOTE: the storage array has no reset; entries are only read while counted as occupied.
   always_ff @(posedge clock) begin
      if (push) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         gap_q         <= '0;
         disp_change_q <= 1'b0;
         disp_output_q <= 1'b0;
         disp_clear_q  <= 1'b0;
         disp_data_q   <= '0;
      end else begin
         disp_change_q <= 1'b0;
         disp_output_q <= 1'b0;
         disp_clear_q  <= 1'b0;
         if (clear_req && !in_clear) begin
            state_q      <= ST_CLEAR;
            disp_clear_q <= 1'b1;
            disp_data_q  <= '0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (count_q != '0) begin
                     state_q       <= ST_ISSUE;
                     disp_change_q <= 1'b1;
                     disp_output_q <= 1'b1;
                     disp_data_q   <= mem_q[rd_ptr_q];
                  end
               end
               ST_ISSUE: begin
                  state_q <= ST_HOLD;
                  gap_q   <= GW'(GAP - 1);
               end
               // HOLD runs GAP-1 cycles; the IDLE cycle after it completes the spacing.
               ST_HOLD: begin
                  gap_q <= gap_q - 1'b1;
                  if (gap_q <= GW'(1)) begin
                     state_q <= ST_IDLE;
                  end
               end
               ST_CLEAR: begin
                  state_q <= ST_IDLE;
                  gap_q   <= '0;
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign req_ack     = grant;
   assign disp_change = disp_change_q;
   assign disp_output = disp_output_q;
   assign disp_clear  = disp_clear_q;
   assign disp_data   = disp_data_q;
   assign fifo_count  = count_q;
   assign busy        = (count_q != '0) || (state_q != ST_IDLE);

endmodule
